// File: rtl/cpu_controller.sv
// Multi-cycle fetch/decode/execute controller for the 16-bit SimpleRISC datapath.
// Optional branch support is enabled by defining CPU_CONTROLLER_BRANCH_EN.
module cpu_controller (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] instr,
    input  logic [2:0]  status,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic [1:0]  vsel,
    output logic [1:0]  asel,
    output logic [1:0]  bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        write,
    output logic        load_ir,
    output logic        load_pc,
    output logic        reset_pc,
    output logic        pc_sel,
    output logic        load_addr,
    output logic        addr_sel,
    output logic [1:0]  mem_cmd,
    output logic        halted,
    output logic [4:0]  state_o
);

    typedef enum logic [4:0] {
        S_RST  = 5'd0,
        S_IF1  = 5'd1,
        S_IF2  = 5'd2,
        S_UPD  = 5'd3,
        S_DEC  = 5'd4,
        S_WIMM = 5'd5,
        S_GA   = 5'd6,
        S_GB   = 5'd7,
        S_EX   = 5'd8,
        S_WR   = 5'd9,
        S_AD   = 5'd10,
        S_LA   = 5'd11,
        S_MRD  = 5'd12,
        S_MWB  = 5'd13,
        S_SB   = 5'd14,
        S_SC   = 5'd15,
        S_MWR  = 5'd16,
        S_HALT = 5'd17
`ifdef CPU_CONTROLLER_BRANCH_EN
        ,
        S_BR1  = 5'd18,
        S_BR2  = 5'd19
`endif
    } state_t;

    localparam logic [1:0] MEM_NONE = 2'b00;
    localparam logic [1:0] MEM_RD   = 2'b01;
    localparam logic [1:0] MEM_WR   = 2'b10;

    state_t state_q;
    state_t state_d;

    logic [2:0] opcode;
    logic [1:0] op;
    logic [4:0] opc_op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [2:0] rm;
    logic [1:0] sh;
    logic       is_cmp;
    logic       is_mov_reg;
    logic       is_ldr;

    assign opcode     = instr[15:13];
    assign op         = instr[12:11];
    assign opc_op     = instr[15:11];
    assign rn         = instr[10:8];
    assign rd         = instr[7:5];
    assign sh         = instr[4:3];
    assign rm         = instr[2:0];
    assign is_cmp     = (opc_op == 5'b101_01);
    assign is_mov_reg = (opcode == 3'b110);
    assign is_ldr     = (opcode == 3'b011);
    assign state_o    = state_q;

`ifdef CPU_CONTROLLER_BRANCH_EN
    logic [2:0] cond;
    logic       flag_z;
    logic       flag_v;
    logic       flag_n;
    logic       br_taken;

    assign cond   = instr[10:8];
    assign flag_z = status[2];
    assign flag_v = status[1];
    assign flag_n = status[0];

    // Signed less-than is N xor V; conditions 101-111 are reserved and never taken.
    always_comb begin
        br_taken = 1'b0;
        case (cond)
            3'b000:  br_taken = 1'b1;
            3'b001:  br_taken = flag_z;
            3'b010:  br_taken = ~flag_z;
            3'b011:  br_taken = flag_n ^ flag_v;
            3'b100:  br_taken = (flag_n ^ flag_v) | flag_z;
            default: br_taken = 1'b0;
        endcase
    end
`else
    logic unused_status;
    assign unused_status = ^status;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        readnum   = 3'd0;
        writenum  = 3'd0;
        vsel      = 2'b00;
        asel      = 2'b00;
        bsel      = 2'b00;
        shift     = 2'b00;
        ALUop     = 2'b00;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        write     = 1'b0;
        load_ir   = 1'b0;
        load_pc   = 1'b0;
        reset_pc  = 1'b0;
        pc_sel    = 1'b0;
        load_addr = 1'b0;
        addr_sel  = 1'b0;
        mem_cmd   = MEM_NONE;
        halted    = 1'b0;

        case (state_q)
            S_RST: begin
                reset_pc = 1'b1;
                load_pc  = 1'b1;
                state_d  = S_IF1;
            end
            S_IF1: begin
                addr_sel = 1'b1;
                mem_cmd  = MEM_RD;
                state_d  = S_IF2;
            end
            // Read data is valid in IF2, so the IR captures it at the end of this cycle.
            S_IF2: begin
                addr_sel = 1'b1;
                mem_cmd  = MEM_RD;
                load_ir  = 1'b1;
                state_d  = S_UPD;
            end
            S_UPD: begin
                load_pc = 1'b1;
                state_d = S_DEC;
            end
            S_DEC: begin
                state_d = S_IF1;
                if (opcode == 3'b111) begin
                    state_d = S_HALT;
                end else begin
                    case (opc_op)
                        5'b110_10:                      state_d = S_WIMM;
                        5'b110_00, 5'b101_11:           state_d = S_GB;
                        5'b101_00, 5'b101_01, 5'b101_10: state_d = S_GA;
                        5'b011_00, 5'b100_00:           state_d = S_GA;
`ifdef CPU_CONTROLLER_BRANCH_EN
                        5'b001_00: if (br_taken) state_d = S_BR1;
`endif
                        default:                        state_d = S_IF1;
                    endcase
                end
            end
            S_WIMM: begin
                vsel     = 2'b10;
                writenum = rn;
                write    = 1'b1;
                state_d  = S_IF1;
            end
            S_GA: begin
                readnum = rn;
                loada   = 1'b1;
                state_d = (opcode == 3'b101) ? S_GB : S_AD;
            end
            S_GB: begin
                readnum = rm;
                loadb   = 1'b1;
                state_d = S_EX;
            end
            // Register MOV forces A to zero so the ALU passes the shifted B operand.
            S_EX: begin
                asel    = is_mov_reg ? 2'b01 : 2'b00;
                bsel    = 2'b00;
                shift   = sh;
                ALUop   = op;
                loadc   = 1'b1;
                loads   = is_cmp;
                state_d = is_cmp ? S_IF1 : S_WR;
            end
            S_WR: begin
                vsel     = 2'b00;
                writenum = rd;
                write    = 1'b1;
                state_d  = S_IF1;
            end
            S_AD: begin
                asel    = 2'b00;
                bsel    = 2'b01;
                ALUop   = 2'b00;
                loadc   = 1'b1;
                state_d = S_LA;
            end
            S_LA: begin
                load_addr = 1'b1;
                state_d   = is_ldr ? S_MRD : S_SB;
            end
            S_MRD: begin
                mem_cmd = MEM_RD;
                state_d = S_MWB;
            end
            S_MWB: begin
                mem_cmd  = MEM_RD;
                vsel     = 2'b01;
                writenum = rd;
                write    = 1'b1;
                state_d  = S_IF1;
            end
            S_SB: begin
                readnum = rd;
                loadb   = 1'b1;
                state_d = S_SC;
            end
            S_SC: begin
                asel    = 2'b01;
                bsel    = 2'b00;
                shift   = 2'b00;
                ALUop   = 2'b00;
                loadc   = 1'b1;
                state_d = S_MWR;
            end
            S_MWR: begin
                mem_cmd = MEM_WR;
                state_d = S_IF1;
            end
`ifdef CPU_CONTROLLER_BRANCH_EN
            // PC already holds address+1 here, so PC + sximm8 gives the branch target.
            S_BR1: begin
                asel    = 2'b10;
                bsel    = 2'b10;
                ALUop   = 2'b00;
                loadc   = 1'b1;
                state_d = S_BR2;
            end
            S_BR2: begin
                load_pc = 1'b1;
                pc_sel  = 1'b1;
                state_d = S_IF1;
            end
`endif
            S_HALT: begin
                halted  = 1'b1;
                state_d = S_HALT;
            end
            default: begin
                state_d = S_RST;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: an instruction-level trace model predicts every control word
// cycle by cycle; a few literal probes pin the model. Also builds with CPU_CONTROLLER_BRANCH_EN.
module tb_cpu_controller;

    typedef struct packed {
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic [1:0] vsel;
        logic [1:0] asel;
        logic [1:0] bsel;
        logic [1:0] shift;
        logic [1:0] alu_op;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       write;
        logic       load_ir;
        logic       load_pc;
        logic       reset_pc;
        logic       pc_sel;
        logic       load_addr;
        logic       addr_sel;
        logic [1:0] mem_cmd;
        logic       halted;
    } ctl_t;

    localparam int CW        = $bits(ctl_t);
    localparam int HALT_HOLD = 20;

    logic        clk;
    logic        reset_n;
    logic [15:0] instr;
    logic [2:0]  status;
    logic [2:0]  readnum, writenum;
    logic [1:0]  vsel, asel, bsel, shift, alu_op, mem_cmd;
    logic        loada, loadb, loadc, loads, write, load_ir, load_pc, reset_pc, pc_sel;
    logic        load_addr, addr_sel, halted;
    logic [4:0]  dbg_state;

    cpu_controller dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .instr    (instr),
        .status   (status),
        .readnum  (readnum),
        .writenum (writenum),
        .vsel     (vsel),
        .asel     (asel),
        .bsel     (bsel),
        .shift    (shift),
        .ALUop    (alu_op),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .write    (write),
        .load_ir  (load_ir),
        .load_pc  (load_pc),
        .reset_pc (reset_pc),
        .pc_sel   (pc_sel),
        .load_addr(load_addr),
        .addr_sel (addr_sel),
        .mem_cmd  (mem_cmd),
        .halted   (halted),
        .state_o  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [CW-1:0] exp_q[$];
    string         name_q[$];
    int            push_cnt = 0;
    int            n_cmp    = 0;
    int            n_err    = 0;
    ctl_t          dut_ctl;

    always_comb begin
        dut_ctl           = '0;
        dut_ctl.readnum   = readnum;
        dut_ctl.writenum  = writenum;
        dut_ctl.vsel      = vsel;
        dut_ctl.asel      = asel;
        dut_ctl.bsel      = bsel;
        dut_ctl.shift     = shift;
        dut_ctl.alu_op    = alu_op;
        dut_ctl.loada     = loada;
        dut_ctl.loadb     = loadb;
        dut_ctl.loadc     = loadc;
        dut_ctl.loads     = loads;
        dut_ctl.write     = write;
        dut_ctl.load_ir   = load_ir;
        dut_ctl.load_pc   = load_pc;
        dut_ctl.reset_pc  = reset_pc;
        dut_ctl.pc_sel    = pc_sel;
        dut_ctl.load_addr = load_addr;
        dut_ctl.addr_sel  = addr_sel;
        dut_ctl.mem_cmd   = mem_cmd;
        dut_ctl.halted    = halted;
    end

    always @(negedge clk) begin
        logic [CW-1:0] e;
        string         nm;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_cmp++;
            if (dut_ctl !== ctl_t'(e)) begin
                n_err++;
                $display("FAIL %s @%0t: got ctl=%h required ctl=%h", nm, $time, dut_ctl, e);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d required %0d", nm, $time, act, req);
        end
    endtask

    task automatic push(input string nm, input ctl_t c);
        exp_q.push_back(c);
        name_q.push_back(nm);
        push_cnt++;
    endtask

    // ---------------- instruction-level model ----------------
    task automatic model_instr(input logic [15:0] ins, input logic [2:0] st, output int n);
        logic [2:0] opc, rn, rd, rm;
        logic [1:0] op, sh;
        logic       z, v, ng;
        bit         taken;
        ctl_t       c;
        int         start;
        opc = ins[15:13]; op = ins[12:11]; rn = ins[10:8];
        rd  = ins[7:5];   sh = ins[4:3];   rm = ins[2:0];
        z = st[2]; v = st[1]; ng = st[0];
        start = push_cnt;

        c = '0; c.addr_sel = 1'b1; c.mem_cmd = 2'b01; push("if1", c);
        c.load_ir = 1'b1; push("if2", c);
        c = '0; c.load_pc = 1'b1; push("upd", c);
        c = '0; push("dec", c);

        if (opc == 3'b111) begin
            c = '0; c.halted = 1'b1;
            repeat (HALT_HOLD) push("halt", c);
        end else if (opc == 3'b110 && op == 2'b10) begin
            c = '0; c.vsel = 2'b10; c.writenum = rn; c.write = 1'b1; push("mov_imm_write", c);
        end else if ((opc == 3'b110 && op == 2'b00) || opc == 3'b101) begin
            if (opc == 3'b101 && op != 2'b11) begin
                c = '0; c.readnum = rn; c.loada = 1'b1; push("get_a", c);
            end
            c = '0; c.readnum = rm; c.loadb = 1'b1; push("get_b", c);
            c = '0; c.asel = (opc == 3'b110) ? 2'b01 : 2'b00; c.shift = sh; c.alu_op = op;
            c.loadc = 1'b1; c.loads = (opc == 3'b101 && op == 2'b01); push("execute", c);
            if (!(opc == 3'b101 && op == 2'b01)) begin
                c = '0; c.writenum = rd; c.write = 1'b1; push("write_back", c);
            end
        end else if ((opc == 3'b011 || opc == 3'b100) && op == 2'b00) begin
            c = '0; c.readnum = rn; c.loada = 1'b1; push("mem_get_a", c);
            c = '0; c.bsel = 2'b01; c.loadc = 1'b1; push("mem_addr_calc", c);
            c = '0; c.load_addr = 1'b1; push("mem_load_addr", c);
            if (opc == 3'b011) begin
                c = '0; c.mem_cmd = 2'b01; push("ldr_read", c);
                c.vsel = 2'b01; c.writenum = rd; c.write = 1'b1; push("ldr_writeback", c);
            end else begin
                c = '0; c.readnum = rd; c.loadb = 1'b1; push("str_get_data", c);
                c = '0; c.asel = 2'b01; c.loadc = 1'b1; push("str_pass_data", c);
                c = '0; c.mem_cmd = 2'b10; push("str_write", c);
            end
        end
`ifdef CPU_CONTROLLER_BRANCH_EN
        else if (opc == 3'b001 && op == 2'b00) begin
            case (rn)
                3'd0:    taken = 1'b1;
                3'd1:    taken = z;
                3'd2:    taken = !z;
                3'd3:    taken = (ng != v);
                3'd4:    taken = (ng != v) || z;
                default: taken = 1'b0;
            endcase
            if (taken) begin
                c = '0; c.asel = 2'b10; c.bsel = 2'b10; c.loadc = 1'b1; push("br_target", c);
                c = '0; c.load_pc = 1'b1; c.pc_sel = 1'b1; push("br_load_pc", c);
            end
        end
`endif
        n = push_cnt - start;
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] ins, input logic [2:0] st, output int n);
        instr  = ins;
        status = st;
        model_instr(ins, st, n);
    endtask

    task automatic run(input string nm, input logic [15:0] ins, input logic [2:0] st,
                       input int req_len);
        int n;
        issue(ins, st, n);
        chk({"len_", nm}, n, req_len);
        cycles(n);
    endtask

    task automatic push_rst();
        ctl_t c;
        c = '0; c.reset_pc = 1'b1; c.load_pc = 1'b1;
        push("reset", c);
    endtask

    // ---------------- stimulus ----------------
    logic [15:0] br_ins  [9] = '{16'h2003, 16'h2103, 16'h2103, 16'h2203, 16'h2303,
                                 16'h2303, 16'h2403, 16'h2403, 16'h2503};
    logic [2:0]  br_st   [9] = '{3'b000, 3'b100, 3'b000, 3'b000, 3'b001,
                                 3'b011, 3'b100, 3'b010, 3'b111};
    bit          br_take [9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        int n;
        reset_n = 1'b1;
        instr   = 16'h0000;
        status  = 3'b000;
        #1 reset_n = 1'b0;
        repeat (3) push_rst();
        @(negedge clk); #1;
        chk("reset_reset_pc", int'(reset_pc), 1);
        chk("reset_load_pc", int'(load_pc), 1);
        chk("reset_halted", int'(halted), 0);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        chk("first_if1_mem_cmd", int'(mem_cmd), 1);
        chk("first_if1_addr_sel", int'(addr_sel), 1);

        // MOV R3,#7 with literal probes in the write cycle
        issue(16'hD307, 3'b000, n);
        chk("len_mov_imm", n, 5);
        cycles(4);
        chk("mov_imm_vsel", int'(vsel), 2);
        chk("mov_imm_writenum", int'(writenum), 3);
        chk("mov_imm_write", int'(write), 1);
        cycles(1);

        // ADD R2,R1,R0,LSL#1 with probes per micro-step
        issue(16'hA148, 3'b000, n);
        chk("len_add", n, 8);
        cycles(4);
        chk("add_ga_readnum", int'(readnum), 1);
        cycles(1);
        chk("add_gb_readnum", int'(readnum), 0);
        cycles(1);
        chk("add_ex_shift", int'(shift), 1);
        chk("add_ex_aluop", int'(alu_op), 0);
        cycles(1);
        chk("add_wr_writenum", int'(writenum), 2);
        cycles(1);

        run("mov_reg", 16'hC0B6, 3'b000, 7);
        run("and", 16'hB782, 3'b000, 8);
        run("mvn", 16'hB8C5, 3'b000, 7);
        run("cmp", 16'hA91B, 3'b000, 7);

        for (int i = 0; i < 9; i++) begin
`ifdef CPU_CONTROLLER_BRANCH_EN
            run($sformatf("branch%0d", i), br_ins[i], br_st[i], br_take[i] ? 6 : 4);
`else
            run($sformatf("branch%0d", i), br_ins[i], br_st[i], 4);
`endif
        end

`ifdef CPU_CONTROLLER_BRANCH_EN
        issue(16'h2103, 3'b100, n);
        cycles(4);
        chk("beq_br1_asel", int'(asel), 2);
        chk("beq_br1_bsel", int'(bsel), 2);
        cycles(1);
        chk("beq_br2_load_pc", int'(load_pc), 1);
        chk("beq_br2_pc_sel", int'(pc_sel), 1);
        cycles(1);
`endif

        // LDR R1,[R2,#1] then STR R1,[R2,#1]
        issue(16'h6221, 3'b000, n);
        chk("len_ldr", n, 9);
        cycles(6);
        chk("ldr_la_load_addr", int'(load_addr), 1);
        cycles(2);
        chk("ldr_mwb_addr_sel", int'(addr_sel), 0);
        chk("ldr_mwb_vsel", int'(vsel), 1);
        chk("ldr_mwb_writenum", int'(writenum), 1);
        cycles(1);
        issue(16'h8221, 3'b000, n);
        chk("len_str", n, 10);
        cycles(9);
        chk("str_mwr_mem_cmd", int'(mem_cmd), 2);
        cycles(1);
        chk("str_after_mwr_mem_cmd", int'(mem_cmd), 1);

        run("nop_000", 16'h0000, 3'b000, 4);
        run("nop_110_01", 16'hC800, 3'b000, 4);
        run("nop_011_01", 16'h6800, 3'b000, 4);
        run("nop_100_10", 16'h9000, 3'b000, 4);

        // Reset pulsed during the STR data-pass cycle: the store must never issue
        issue(16'h8221, 3'b000, n);
        void'(exp_q.pop_back());
        void'(name_q.pop_back());
        cycles(8);
        @(negedge clk); #1 reset_n = 1'b0;
        #1;
        chk("abort_mem_cmd", int'(mem_cmd), 0);
        chk("abort_reset_pc", int'(reset_pc), 1);
        chk("abort_write", int'(write), 0);
        repeat (2) begin
            @(posedge clk); #1;
            push_rst();
        end
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk); #1;

        run("mov_after_reset", 16'hD503, 3'b000, 5);

        // HALT holds indefinitely
        issue(16'hE000, 3'b000, n);
        chk("len_halt", n, 4 + HALT_HOLD);
        cycles(n);
        chk("halt_still_halted", int'(halted), 1);
        chk("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Multi-cycle control FSM for the 16-bit SimpleRISC CPU. It fetches each instruction from memory, decodes the instruction register, and sequences the register-file/ALU datapath one micro-step per clock. It also drives PC, instruction-register, data-address and memory-command controls. It sits between the instruction register and the datapath, replacing all hand-driven control inputs.

## Interface
- No parameters; all widths fixed by the ISA.
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- instr  in  16  instruction register output; fields: opcode[15:13], op[12:11], Rn[10:8], Rd[7:5], shift[4:3], Rm[2:0], cond[10:8]
- status  in  3  datapath status {Z,V,N}: [2]=Z, [1]=V, [0]=N
- readnum, writenum  out  3 each  register-file read/write index
- vsel, asel, bsel  out  2 each  datapath mux selects (vsel 00=C, 01=mdata, 10=sximm8; asel 00=A, 01=0, 10=PC; bsel 00=shifter, 01=sximm5, 10=sximm8)
- shift, ALUop  out  2 each  shifter op; ALU op (00 add, 01 sub, 10 and, 11 not-B)
- loada, loadb, loadc, loads, write  out  1 each  datapath load/write strobes
- load_ir, load_pc, reset_pc, pc_sel  out  1 each  IR load; PC load; PC←0; PC source (0=PC+1, 1=datapath_out[7:0])
- load_addr, addr_sel  out  1 each  data-address register load; memory address source (1=PC, 0=data address)
- mem_cmd  out  2  00 none, 01 read, 10 write
- halted  out  1  high while in HALT

## Operation
- Moore FSM; every output is decoded from state plus instr fields. Unlisted outputs are 0 in every state.
- RST: reset_pc=1, load_pc=1 → IF1.
- IF1: addr_sel=1, mem_cmd=01 → IF2.
- IF2: addr_sel=1, mem_cmd=01, load_ir=1 → UPD.
- UPD: load_pc=1, pc_sel=0 → DEC.
- DEC: no strobes; dispatch on {opcode,op}.
- MOV Rn,#im8 (110/10): WIMM (vsel=10, writenum=Rn, write) → IF1.
- MOV Rd,Rm{,sh} (110/00): GB → EX(asel=01, ALUop=00) → WR.
- ADD/AND (101/00, 101/10): GA → GB → EX → WR.
- CMP (101/01): GA → GB → EX(loads=1) → IF1.
- MVN (101/11): GB → EX → WR.
- GA: readnum=Rn, loada. GB: readnum=Rm, loadb. EX: asel=00 unless noted, bsel=00, shift=instr[4:3], ALUop=op, loadc. WR: vsel=00, writenum=Rd, write → IF1.
- LDR (011/00): GA → AD(asel=00, bsel=01, ALUop=00, loadc) → LA(load_addr) → MRD(addr_sel=0, mem_cmd=01) → MWB(addr_sel=0, mem_cmd=01, vsel=01, writenum=Rd, write) → IF1.
- STR (100/00): GA → AD → LA → SB(readnum=Rd, loadb) → SC(asel=01, bsel=00, shift=00, ALUop=00, loadc) → MWR(addr_sel=0, mem_cmd=10) → IF1.
- Branch (001/00), cond 000 B, 001 BEQ (Z), 010 BNE (!Z), 011 BLT (N≠V), 100 BLE (N≠V or Z):
  - DEC evaluates the condition on current status.
  - Taken: BR1(asel=10, bsel=10, ALUop=00, loadc) → BR2(load_pc, pc_sel=1) → IF1. Target = (address+1) + sximm8, truncated to 8 bits.
  - Not taken, or cond 101–111: → IF1.
- HALT (111/xx): state HALT, halted=1. Held until reset_n.
- Any other {opcode,op}: treated as NOP, DEC → IF1. No register, status or memory effect.

## Timing
- reset_n low: state=RST immediately. Outputs are RST values (reset_pc=1, load_pc=1, rest 0, halted=0). Reset mid-instruction abandons it; no write strobe is issued after reset assertion.
- First IF1 is on the first rising edge after reset_n deasserts.
- Memory is synchronous, 1-cycle read latency. The address and mem_cmd for a read are held two consecutive cycles (IF1/IF2, MRD/MWB).
- Cycles per instruction, IF1 through last state inclusive:
  - MOV imm 5; MOV reg 7; ALU 8; CMP 7; MVN 7; LDR 9; STR 10.
  - Branch taken 6; not taken 4; NOP 4.
- Status used by branches is the value registered by the most recent CMP.

## Configuration
- CPU_CONTROLLER_BRANCH_EN defined: branch decode and states BR1/BR2 present, as above.
- Undefined: BR1/BR2 omitted. Opcode 001 decodes as NOP (DEC → IF1, 4 cycles), and pc_sel is tied to 0.

## Test plan
- Reset: hold reset_n=0 → reset_pc=1, load_pc=1, halted=0. Release → IF1 with mem_cmd=01, addr_sel=1 next cycle.
- MOV R3,#7 (0xD307): in WIMM, vsel=10, writenum=3, write=1 for exactly one cycle; back to IF1 5 cycles after IF1 start.
- ADD R2,R1,R0,LSL#1 (0xA148): GA readnum=1, GB readnum=0, EX shift=01, ALUop=00, WR writenum=2. Total 8 cycles.
- CMP then BEQ +3: status=100 → BR1 asel=10, bsel=10, then BR2 load_pc=1, pc_sel=1. Status=000 → DEC → IF1 with no load_pc.
- LDR R1,[R2,#1] then STR R1,[R2,#1]: check LA load_addr, MRD/MWB addr_sel=0, mem_cmd=01, MWB vsel=01, writenum=1; MWR mem_cmd=10 exactly one cycle.
- HALT (0xE000): halted stays 1 for 20 cycles. reset_n pulsed low during a STR's SC state → RST, no MWR issued.
